// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing path.
// Holds the line-phase encoding used by vga_phase_seq and anything that
// decodes its `phase` output.
package vga_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_IDLE   = 3'd0;
  localparam phase_t PH_ACTIVE = 3'd1;
  localparam phase_t PH_FRONT  = 3'd2;
  localparam phase_t PH_SYNC   = 3'd3;
  localparam phase_t PH_BACK   = 3'd4;

endpackage

// File: rtl/vga_phase_seq.sv
// vga_phase_seq: line timing sequencer (horizontal or vertical).
// Walks ACTIVE -> FRONT -> SYNC -> BACK, reloading an external down-counter
// with each phase length and advancing on its terminal-count pulse.
//
// Ports:
//   clk, reset          clock, async active-low reset
//   enable              run request (looked at in IDLE and at line end)
//   len_active/front/sync/back   phase lengths in clocks (0 treated as 1)
//   cnt_int             terminal-count pulse from the counter
//   cnt_set, cnt_val    counter load strobe and reload value (length - 1)
//   phase               current state encoding
//   active_out          high during ACTIVE
//   sync_out            SYNC_POL during SYNC, ~SYNC_POL otherwise
//   line_end            pulse in the last cycle of BACK
module vga_phase_seq
  import vga_pkg::*;
#(
  parameter int   W        = 32,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] len_active,
  input  logic [W-1:0] len_front,
  input  logic [W-1:0] len_sync,
  input  logic [W-1:0] len_back,
  input  logic         cnt_int,
  output logic         cnt_set,
  output logic [W-1:0] cnt_val,
  output logic [2:0]   phase,
  output logic         active_out,
  output logic         sync_out,
  output logic         line_end
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Zero is stored as one so a later reload can never underflow.
  function automatic logic [W-1:0] clamp_len(input logic [W-1:0] l);
    return (l == '0) ? ONE : l;
  endfunction

  // Reload value for a length; 0 and 1 both map to 0, never all-ones.
  function automatic logic [W-1:0] reload(input logic [W-1:0] l);
    return (l == '0) ? '0 : l - ONE;
  endfunction

  phase_t       state_q, state_d;
  logic [W-1:0] sh_front_q, sh_front_d;
  logic [W-1:0] sh_sync_q,  sh_sync_d;
  logic [W-1:0] sh_back_q,  sh_back_d;
  logic         line_start;

  // The active length is consumed by the load issued at line start itself,
  // straight from the input, so only the three later phases need shadows.

  // State and shadow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PH_IDLE;
      sh_front_q <= '0;
      sh_sync_q  <= '0;
      sh_back_q  <= '0;
    end else begin
      state_q    <= state_d;
      sh_front_q <= sh_front_d;
      sh_sync_q  <= sh_sync_d;
      sh_back_q  <= sh_back_d;
    end
  end

  // Next state; shadows refresh only when a new line begins
  always_comb begin
    state_d    = state_q;
    line_start = 1'b0;
    case (state_q)
      PH_IDLE: if (enable) begin
        state_d    = PH_ACTIVE;
        line_start = 1'b1;
      end
      PH_ACTIVE: if (cnt_int) state_d = PH_FRONT;
      PH_FRONT:  if (cnt_int) state_d = PH_SYNC;
      PH_SYNC:   if (cnt_int) state_d = PH_BACK;
      PH_BACK: if (cnt_int) begin
        if (enable) begin
          state_d    = PH_ACTIVE;
          line_start = 1'b1;
        end else begin
          state_d = PH_IDLE;
        end
      end
      default: state_d = PH_IDLE;
    endcase

    sh_front_d = sh_front_q;
    sh_sync_d  = sh_sync_q;
    sh_back_d  = sh_back_q;
    if (line_start) begin
      sh_front_d = clamp_len(len_front);
      sh_sync_d  = clamp_len(len_sync);
      sh_back_d  = clamp_len(len_back);
    end
  end

  // Outputs. The counter strobe is gated by reset so nothing is loaded
  // while reset holds the state in IDLE with enable high.
  always_comb begin
    cnt_set    = 1'b0;
    cnt_val    = '0;
    line_end   = 1'b0;
    phase      = state_q;
    active_out = (state_q == PH_ACTIVE);
    sync_out   = (state_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    if (reset) begin
      case (state_q)
        PH_IDLE: if (enable) begin
          cnt_set = 1'b1;
          cnt_val = reload(len_active);
        end
        PH_ACTIVE: if (cnt_int) begin
          cnt_set = 1'b1;
          cnt_val = reload(sh_front_q);
        end
        PH_FRONT: if (cnt_int) begin
          cnt_set = 1'b1;
          cnt_val = reload(sh_sync_q);
        end
        PH_SYNC: if (cnt_int) begin
          cnt_set = 1'b1;
          cnt_val = reload(sh_back_q);
        end
        PH_BACK: if (cnt_int) begin
          line_end = 1'b1;
          if (enable) begin
            cnt_set = 1'b1;
            cnt_val = reload(len_active);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_phase_seq.sv
// Bench for vga_phase_seq: two instances (SYNC_POL 0 and 1), each driving a
// behavioural down-counter, checked every cycle against a phase/elapsed-time
// model of the line.
module tb_vga_phase_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] la = '0, lf = '0, ls = '0, lb = '0;

  logic         cnt_int0, cnt_set0, act0, sync0, le0;
  logic         cnt_int1, cnt_set1, act1, sync1, le1;
  logic [W-1:0] cnt_val0, cnt_val1;
  logic [2:0]   phase0, phase1;

  always #5 clk = ~clk;

  vga_phase_seq #(.W(W), .SYNC_POL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .len_active(la), .len_front(lf), .len_sync(ls), .len_back(lb),
    .cnt_int(cnt_int0), .cnt_set(cnt_set0), .cnt_val(cnt_val0),
    .phase(phase0), .active_out(act0), .sync_out(sync0), .line_end(le0));

  vga_phase_seq #(.W(W), .SYNC_POL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .len_active(la), .len_front(lf), .len_sync(ls), .len_back(lb),
    .cnt_int(cnt_int1), .cnt_set(cnt_set1), .cnt_val(cnt_val1),
    .phase(phase1), .active_out(act1), .sync_out(sync1), .line_end(le1));

  // Counter stand-ins: load val on set, else count down; terminal at zero.
  logic [W-1:0] cq0, cq1;
  always @(posedge clk or negedge reset)
    if (!reset) cq0 <= '0; else if (cnt_set0) cq0 <= cnt_val0; else cq0 <= cq0 - 1;
  always @(posedge clk or negedge reset)
    if (!reset) cq1 <= '0; else if (cnt_set1) cq1 <= cnt_val1; else cq1 <= cq1 - 1;
  assign cnt_int0 = (cq0 == '0);
  assign cnt_int1 = (cq1 == '0);

  // Model: phase index 0..4 (idle, active, front, sync, back), cycles
  // elapsed in the phase (1-based), and the lengths captured for this line.
  int m_ph, m_cnt;
  int m_len[5];
  int passed = 0, total = 0;
  int n_act, n_slo, n_le, n_set;

  function automatic int cl(input int l);
    return (l == 0) ? 1 : l;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ph = 0; m_cnt = 0;
    for (int i = 0; i < 5; i++) m_len[i] = 0;
  endtask

  function automatic bit m_last();
    return (m_ph != 0) && (m_cnt == m_len[m_ph]);
  endfunction

  task automatic clr();
    n_act = 0; n_slo = 0; n_le = 0; n_set = 0;
  endtask

  task automatic check();
    bit e_set, e_le;
    int e_val;
    e_set = 0; e_le = 0; e_val = 0;
    if (reset) begin
      if (m_ph == 0) begin
        if (enable) begin e_set = 1; e_val = cl(int'(la)) - 1; end
      end else if (m_last()) begin
        if (m_ph < 4) begin e_set = 1; e_val = m_len[m_ph + 1] - 1; end
        else begin
          e_le = 1;
          if (enable) begin e_set = 1; e_val = cl(int'(la)) - 1; end
        end
      end
    end
    chk("phase",    64'(phase0),   64'(m_ph));
    chk("active",   64'(act0),     64'(m_ph == 1));
    chk("sync_p0",  64'(sync0),    64'(m_ph != 3));
    chk("sync_p1",  64'(sync1),    64'(m_ph == 3));
    chk("line_end", 64'(le0),      64'(e_le));
    chk("cnt_set",  64'(cnt_set0), 64'(e_set));
    chk("cnt_val",  64'(cnt_val0), 64'(e_val));
    chk("val_nowrap", 64'(cnt_val0 == '1), 64'(0));
    n_act += int'(act0);
    n_slo += int'(!sync0);
    n_le  += int'(le0);
    n_set += int'(cnt_set0);
  endtask

  task automatic model_update();
    if (!reset) model_reset();
    else if ((m_ph == 0 && enable) || (m_ph == 4 && m_last() && enable)) begin
      m_len[1] = cl(int'(la)); m_len[2] = cl(int'(lf));
      m_len[3] = cl(int'(ls)); m_len[4] = cl(int'(lb));
      m_ph = 1; m_cnt = 1;
    end else if (m_last()) begin
      if (m_ph < 4) begin m_ph++; m_cnt = 1; end
      else begin m_ph = 0; m_cnt = 0; end
    end else if (m_ph != 0) m_cnt++;
  endtask

  // One clock: check just after the falling edge, advance model at rise.
  task automatic step();
    #1 check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic restart();
    reset = 1'b0;
    model_reset();
    run(1);
    reset = 1'b1;
  endtask

  task automatic set_len(input int a, input int f, input int s, input int b);
    la = W'(a); lf = W'(f); ls = W'(s); lb = W'(b);
  endtask

  initial begin
    model_reset();
    clr();
    @(negedge clk);
    enable = 1'b1;
    set_len(4, 2, 3, 5);
    run(2);                       // held in reset with enable high

    // Basic line: 14-clock period, repeated
    reset = 1'b1;
    run(1);
    clr(); run(14);
    chk("l1_act", 64'(n_act), 64'(4));
    chk("l1_sync", 64'(n_slo), 64'(3));
    chk("l1_le", 64'(n_le), 64'(1));
    clr(); run(14);
    chk("l2_act", 64'(n_act), 64'(4));
    chk("l2_le", 64'(n_le), 64'(1));

    // Zero front porch clamps to one clock
    set_len(4, 0, 3, 5);
    restart(); run(1);
    clr(); run(13);
    chk("z_le", 64'(n_le), 64'(1));
    chk("z_act", 64'(n_act), 64'(4));
    chk("z_phase", 64'(phase0), 64'(1));

    // Active length change mid-line takes effect next line
    set_len(4, 2, 3, 5);
    restart(); run(1); run(6);
    chk("mid_in_sync", 64'(phase0), 64'(3));
    la = W'(6);
    clr(); run(8);
    chk("mid_cur_act", 64'(n_act), 64'(0));
    chk("mid_cur_le", 64'(n_le), 64'(1));
    clr(); run(16);
    chk("mid_next_act", 64'(n_act), 64'(6));
    chk("mid_next_le", 64'(n_le), 64'(1));

    // Enable dropped during FRONT: line completes, then IDLE
    set_len(4, 2, 3, 5);
    restart(); run(1); run(4);
    chk("en_in_front", 64'(phase0), 64'(2));
    enable = 1'b0;
    clr(); run(10);
    chk("en_le", 64'(n_le), 64'(1));
    chk("en_sets", 64'(n_set), 64'(2));
    clr(); run(3);
    chk("en_idle_sets", 64'(n_set), 64'(0));
    chk("en_idle", 64'(phase0), 64'(0));
    enable = 1'b1;
    #1 chk("en_restart_set", 64'(cnt_set0), 64'(1));
    @(negedge clk);
    chk("en_active", 64'(phase0), 64'(1));
    model_reset(); m_len[1] = 4; m_len[2] = 2; m_len[3] = 3; m_len[4] = 5;
    m_ph = 1; m_cnt = 1;
    run(14);

    // Asynchronous reset in the middle of SYNC
    restart(); run(1); run(7);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("ar_phase", 64'(phase0), 64'(0));
    chk("ar_set", 64'(cnt_set0), 64'(0));
    chk("ar_val", 64'(cnt_val0), 64'(0));
    chk("ar_act", 64'(act0), 64'(0));
    chk("ar_le", 64'(le0), 64'(0));
    chk("ar_sync0", 64'(sync0), 64'(1));
    chk("ar_sync1", 64'(sync1), 64'(0));
    @(negedge clk);
    run(2);
    reset = 1'b1;
    run(1);
    clr(); run(14);
    chk("ar_line_act", 64'(n_act), 64'(4));
    chk("ar_line_sync", 64'(n_slo), 64'(3));
    chk("ar_line_le", 64'(n_le), 64'(1));

    // Random lengths, enable and occasional resets
    repeat (500) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: la = W'($urandom_range(0, 5));
          1: lf = W'($urandom_range(0, 5));
          2: ls = W'($urandom_range(0, 5));
          default: lb = W'($urandom_range(0, 5));
        endcase
      end
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_reset();
      end else reset = 1'b1;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
